// File: rtl/gpio_debounce_pio_if.sv
// ----------------------------------------------------------------------------
// gpio_debounce_pio_if
//   Avalon-MM slave bus bundle for the GPIO peripheral.
//
//   Signals:
//     avs_address   [2:0]  word address
//     avs_read             read strobe
//     avs_write            write strobe
//     avs_writedata [31:0] write data
//     avs_readdata  [31:0] read data, registered, fixed latency of one cycle
//
//   Modports:
//     master : fabric side, drives address/strobes/writedata
//     slave  : peripheral side, drives readdata
// ----------------------------------------------------------------------------
interface gpio_debounce_pio_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/gpio_debounce_pio.sv
// ----------------------------------------------------------------------------
// gpio_debounce_pio
//   GPIO peripheral for an Avalon-MM fabric. Inputs are synchronised,
//   debounced per channel and edge-detected into a sticky capture register
//   that can raise a level interrupt. Outputs come from a register with
//   atomic set/clear aliases.
//
//   Ports:
//     clk       system clock
//     reset     synchronous, active-high reset
//     avs       Avalon-MM slave bundle (gpio_debounce_pio_if.slave)
//     gpio_in   [N_IN-1:0]  asynchronous input pins
//     gpio_out  [N_OUT-1:0] registered output pins
//     irq       registered level interrupt
//
//   Register map (word address):
//     0 DATA_IN  RO   debounced input state
//     1 DATA_OUT RW   output register
//     2 SET_OUT  WO   DATA_OUT |= wdata
//     3 CLR_OUT  WO   DATA_OUT &= ~wdata
//     4 IRQ_MASK RW   per-channel interrupt enable
//     5 EDGE_CAP RW1C sticky edge flags (a new edge beats a same-cycle clear)
//     6 EDGE_POL RW   1 = capture rising, 0 = capture falling
//     7 reserved      reads 0, writes ignored
//
//   Build option:
//     GPIO_DEBOUNCE_EN defined   : per-channel counters require DEB_CYCLES
//                                  stable cycles before an input is accepted.
//     GPIO_DEBOUNCE_EN undefined : the synchronised input is accepted every
//                                  cycle; DEB_CYCLES and CNT_W are unused.
// ----------------------------------------------------------------------------
module gpio_debounce_pio #(
  parameter int              N_IN       = 14,
  parameter int              N_OUT      = 10,
  parameter int              DEB_CYCLES = 50000,
  parameter int              CNT_W      = 16,
  parameter logic [N_IN-1:0] IN_INIT    = '1,
  parameter logic [N_OUT-1:0] OUT_INIT  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  gpio_debounce_pio_if.slave   avs,
  input  logic [N_IN-1:0]      gpio_in,
  output logic [N_OUT-1:0]     gpio_out,
  output logic                 irq
);

  typedef enum logic [2:0] {
    A_DATA_IN  = 3'd0,
    A_DATA_OUT = 3'd1,
    A_SET_OUT  = 3'd2,
    A_CLR_OUT  = 3'd3,
    A_IRQ_MASK = 3'd4,
    A_EDGE_CAP = 3'd5,
    A_EDGE_POL = 3'd6,
    A_RSVD     = 3'd7
  } reg_addr_e;

  reg_addr_e        addr;
  logic [N_IN-1:0]  sync1, sync2;
  logic [N_IN-1:0]  stable, stable_d;
  logic [N_OUT-1:0] data_out;
  logic [N_IN-1:0]  irq_mask, edge_cap, edge_pol;
  logic [N_IN-1:0]  edge_hit, w1c;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Every 3-bit value is a named member, so the cast cannot go out of range.
  assign addr = reg_addr_e'(avs.avs_address);

  // Upper writedata bits are ignored when a channel count is below 32.
  assign unused_wdata = ^avs.avs_writedata;

  // Two-flop synchroniser; both stages start at the idle input level so
  // leaving reset never looks like a pin change.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IN_INIT;
      sync2 <= IN_INIT;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [N_IN-1:0][CNT_W-1:0] cnt;

  // A channel flips only after sync has disagreed with stable for
  // DEB_CYCLES consecutive cycles; any agreement restarts the count.
  // NOTE: counters are ordinary flops, so they are reset like the rest; a
  // reset mid-count must discard partial progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= IN_INIT;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  localparam int unused_deb_cfg = DEB_CYCLES + CNT_W;

  always_ff @(posedge clk) begin
    if (reset) stable <= IN_INIT;
    else       stable <= sync2;
  end
`endif

  // Edge selection: rising where EDGE_POL is 1, falling where it is 0.
  assign edge_hit = (stable & ~stable_d & edge_pol) |
                    (~stable & stable_d & ~edge_pol);

  assign w1c = (avs.avs_write && addr == A_EDGE_CAP) ?
               avs.avs_writedata[N_IN-1:0] : '0;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_DATA_IN:  rd_mux = 32'(stable);
      A_DATA_OUT: rd_mux = 32'(data_out);
      A_IRQ_MASK: rd_mux = 32'(irq_mask);
      A_EDGE_CAP: rd_mux = 32'(edge_cap);
      A_EDGE_POL: rd_mux = 32'(edge_pol);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d         <= IN_INIT;
      data_out         <= OUT_INIT;
      irq_mask         <= '0;
      edge_cap         <= '0;
      edge_pol         <= '0;
      irq              <= 1'b0;
      avs.avs_readdata <= '0;
    end else begin
      stable_d <= stable;
      // The set term is ORed in last so a new edge wins over a same-cycle clear.
      edge_cap <= (edge_cap & ~w1c) | edge_hit;
      irq      <= |(edge_cap & irq_mask);
      // rd_mux is built from pre-edge state, so a read colliding with a
      // write to the same register returns the old contents.
      if (avs.avs_read) avs.avs_readdata <= rd_mux;
      if (avs.avs_write) begin
        case (addr)
          A_DATA_OUT: data_out <= avs.avs_writedata[N_OUT-1:0];
          A_SET_OUT:  data_out <= data_out | avs.avs_writedata[N_OUT-1:0];
          A_CLR_OUT:  data_out <= data_out & ~avs.avs_writedata[N_OUT-1:0];
          A_IRQ_MASK: irq_mask <= avs.avs_writedata[N_IN-1:0];
          A_EDGE_POL: edge_pol <= avs.avs_writedata[N_IN-1:0];
          default:    ;
        endcase
      end
    end
  end

  assign gpio_out = data_out;

endmodule

// File: tb/tb_gpio_debounce_pio.sv
// ----------------------------------------------------------------------------
// tb_gpio_debounce_pio
//   Directed bench for gpio_debounce_pio (N_IN=14, N_OUT=10, DEB_CYCLES=4).
//   A register-map model predicts readdata, gpio_out and irq every cycle;
//   directed sequences add hand-computed literal expectations. Works for
//   both builds (with or without GPIO_DEBOUNCE_EN).
// ----------------------------------------------------------------------------
module tb_gpio_debounce_pio;

  localparam int N_IN  = 14;
  localparam int N_OUT = 10;
  localparam int DEB   = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int D_EFF = DEB;
`else
  localparam int D_EFF = 1;
`endif
  // Cycles from a pin change to DATA_IN.
  localparam int LAT = 2 + D_EFF;
  localparam logic [N_IN-1:0] IDLE = '1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_IN-1:0]  gpio_in = IDLE;
  logic [N_OUT-1:0] gpio_out;
  logic             irq;

  int n_checks = 0;
  int n_errors = 0;

  gpio_debounce_pio_if bus ();

  gpio_debounce_pio #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DEB_CYCLES(DEB), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .avs(bus),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // DATA_IN rule: a channel takes a new value once the pin, seen two cycles
  // late, has shown that value for D_EFF cycles in a row.
  logic [N_IN-1:0]  pin_hist[$];
  logic [N_IN-1:0]  m_stable, m_prev;
  logic [N_OUT-1:0] m_out;
  logic [N_IN-1:0]  m_mask, m_cap, m_pol;
  logic [31:0]      m_rd;
  logic             m_irq;

  always @(posedge clk) begin : model
    logic [N_IN-1:0] nxt, hit, clr, h;
    logic [31:0]     mux;
    logic            all_diff;
    if (reset) begin
      pin_hist.delete();
      for (int k = 0; k < D_EFF + 2; k++) pin_hist.push_back(IDLE);
      m_stable = IDLE; m_prev = IDLE; m_out = '0;
      m_mask = '0; m_cap = '0; m_pol = '0; m_rd = '0; m_irq = 1'b0;
    end else begin
      pin_hist.push_front(gpio_in);
      if (pin_hist.size() > D_EFF + 2) void'(pin_hist.pop_back());
      nxt = m_stable;
      for (int i = 0; i < N_IN; i++) begin
        all_diff = 1'b1;
        for (int k = 2; k < D_EFF + 2; k++) begin
          h = pin_hist[k];
          if (h[i] == m_stable[i]) all_diff = 1'b0;
        end
        if (all_diff) nxt[i] = ~m_stable[i];
      end
      // An edge is a change of DATA_IN seen one cycle after it happened.
      hit = '0;
      for (int i = 0; i < N_IN; i++)
        if (m_stable[i] != m_prev[i] && m_stable[i] == m_pol[i]) hit[i] = 1'b1;
      case (bus.avs_address)
        3'd0:    mux = {18'b0, m_stable};
        3'd1:    mux = {22'b0, m_out};
        3'd4:    mux = {18'b0, m_mask};
        3'd5:    mux = {18'b0, m_cap};
        3'd6:    mux = {18'b0, m_pol};
        default: mux = '0;
      endcase
      if (bus.avs_read) m_rd = mux;
      m_irq = (m_cap & m_mask) != 0;
      clr = (bus.avs_write && bus.avs_address == 3'd5) ? bus.avs_writedata[N_IN-1:0] : '0;
      m_cap = (m_cap & ~clr) | hit;
      if (bus.avs_write) begin
        case (bus.avs_address)
          3'd1: m_out = bus.avs_writedata[N_OUT-1:0];
          3'd2: m_out = m_out | bus.avs_writedata[N_OUT-1:0];
          3'd3: m_out = m_out & ~bus.avs_writedata[N_OUT-1:0];
          3'd4: m_mask = bus.avs_writedata[N_IN-1:0];
          3'd6: m_pol = bus.avs_writedata[N_IN-1:0];
          default: ;
        endcase
      end
      m_prev   = m_stable;
      m_stable = nxt;
    end
  end

  // Compare process: every output, every cycle, on the falling edge.
  always @(negedge clk) begin
    check("mdl_readdata", bus.avs_readdata, m_rd);
    check("mdl_gpio_out", 32'(gpio_out), 32'(m_out));
    check("mdl_irq", 32'(irq), 32'(m_irq));
  end

  // ---------------- bus tasks (called just after a negedge) ----------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic bus_rw(input logic [2:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    bus.avs_address = a; bus.avs_writedata = wd;
    bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    rd = bus.avs_readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic [31:0] rd;
    bus.avs_address = '0; bus.avs_read = 1'b0;
    bus.avs_write = 1'b0; bus.avs_writedata = '0;

    // Reset with all keys idle high.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_gpio_out", 32'(gpio_out), 32'h000);
    check("rst_readdata", bus.avs_readdata, 32'h0);
    bus_read(3'd0, rd); check("rst_data_in", rd, 32'h00003FFF);

    // Output register and its set/clear aliases.
    bus_write(3'd1, 32'h3FF);
    bus_write(3'd3, 32'h00F);
    bus_read(3'd1, rd); check("clr_out_rd", rd, 32'h3F0);
    check("clr_out_pins", 32'(gpio_out), 32'h3F0);
    bus_write(3'd2, 32'h001);
    check("set_out_pins", 32'(gpio_out), 32'h3F1);
    bus_write(3'd1, 32'hFFFFFFFF);
    bus_read(3'd1, rd); check("out_width_mask", rd, 32'h3FF);
    bus_read(3'd2, rd); check("set_out_reads0", rd, 32'h0);
    bus_read(3'd7, rd); check("rsvd_reads0", rd, 32'h0);

    // Press KEY0 (falling edge, EDGE_POL=0) with IRQ_MASK=1; DATA_IN is
    // polled every cycle to pin the latency.
    bus_write(3'd4, 32'h1);
    gpio_in[0] = 1'b0;
    bus.avs_address = 3'd0; bus.avs_read = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (c == LAT)     check("press_before", 32'(bus.avs_readdata[0]), 32'h1);
      if (c == LAT + 1) check("press_after", 32'(bus.avs_readdata[0]), 32'h0);
      if (c == LAT + 1) check("irq_not_yet", 32'(irq), 32'h0);
      if (c == LAT + 2) check("irq_asserts", 32'(irq), 32'h1);
    end
    bus.avs_read = 1'b0;
    bus_read(3'd5, rd); check("edge_cap_set", rd, 32'h1);
    bus_write(3'd5, 32'h1);
    check("irq_lags_clear", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_clears", 32'(irq), 32'h0);
    bus_read(3'd5, rd); check("edge_cap_cleared", rd, 32'h0);

    // Release KEY0: rising edge is ignored with EDGE_POL=0.
    gpio_in[0] = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    bus_read(3'd5, rd); check("rise_ignored", rd, 32'h0);

    // Three-cycle low glitch: filtered only by the debouncer.
    gpio_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(3'd0, rd); check("glitch_data_in", rd, 32'h3FFF);
    bus_read(3'd5, rd); check("glitch_cap", rd, (D_EFF > 3) ? 32'h0 : 32'h1);
    bus_write(3'd5, 32'hFFFFFFFF);

    // One-cycle low pulse on bit 4, DATA_IN polled every cycle.
    gpio_in[4] = 1'b0;
    bus.avs_address = 3'd0; bus.avs_read = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (c == 1) gpio_in[4] = 1'b1;
      if (c == LAT)     check("pulse_pre", 32'(bus.avs_readdata[4]), 32'h1);
      if (c == LAT + 1) check("pulse_seen", 32'(bus.avs_readdata[4]),
                              (D_EFF == 1) ? 32'h0 : 32'h1);
      if (c == LAT + 2) check("pulse_gone", 32'(bus.avs_readdata[4]), 32'h1);
    end
    bus.avs_read = 1'b0;
    repeat (3) @(negedge clk);
    bus_write(3'd5, 32'hFFFFFFFF);
    @(negedge clk);

    // New edge on the same cycle as a W1C of that bit: the set wins.
    gpio_in[0] = 1'b0;
    repeat (LAT) @(negedge clk);
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, rd); check("set_beats_clear", rd, 32'h1);
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, rd); check("cap_clear_again", rd, 32'h0);

    // Rising-edge polarity.
    bus_write(3'd6, 32'h1);
    gpio_in[0] = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    bus_read(3'd5, rd); check("rise_captured", rd, 32'h1);
    bus_write(3'd5, 32'h1);

    // Simultaneous read and write return the pre-write value.
    bus_write(3'd1, 32'h155);
    bus_rw(3'd1, 32'h2AA, rd); check("rw_prewrite", rd, 32'h155);
    check("rw_pins", 32'(gpio_out), 32'h2AA);

    // Reset in the middle of a debounce count.
    gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_out", 32'(gpio_out), 32'h000);
    check("mid_rst_irq", 32'(irq), 32'h0);
    bus.avs_address = 3'd0; bus.avs_read = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c == LAT)     check("mid_rst_restart", 32'(bus.avs_readdata[0]), 32'h1);
      if (c == LAT + 1) check("mid_rst_accept", 32'(bus.avs_readdata[0]), 32'h0);
    end
    bus.avs_read = 1'b0;
    bus_read(3'd4, rd); check("mid_rst_mask", rd, 32'h0);
    bus_read(3'd6, rd); check("mid_rst_pol", rd, 32'h0);
    bus_read(3'd5, rd); check("post_rst_cap", rd, 32'h1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_debounce_pio.md
# gpio_debounce_pio

Parametrised GPIO peripheral on the PULPino Qsys Avalon-MM fabric. It replaces the plain PIO_IN/PIO_OUT pair behind the board's KEY/SW inputs and LEDR outputs. Inputs are synchronised and per-channel debounced, then edge-detected into a sticky capture register that can raise an interrupt. Outputs are driven from a register with atomic set/clear aliases, so firmware needs no read-modify-write.

## Interface
Parameters:
- N_IN, 14, number of input channels (1..32).
- N_OUT, 10, number of output channels (1..32).
- DEB_CYCLES, 50000, consecutive stable cycles required to accept an input change (2..2^CNT_W-1).
- CNT_W, 16, debounce counter width.
- IN_INIT, all ones, reset value of the debounced input state (KEYs idle high).
- OUT_INIT, 0, reset value of gpio_out.

Ports:
- clk, in, 1, system clock; all logic rises on it.
- reset, in, 1, synchronous, active-high reset.
- avs_address, in, 3, word address.
- avs_read, in, 1, read strobe.
- avs_write, in, 1, write strobe.
- avs_writedata, in, 32, write data.
- avs_readdata, out, 32, read data, registered.
- gpio_in, in, N_IN, asynchronous pins.
- gpio_out, out, N_OUT, output pins, registered.
- irq, out, 1, level interrupt, registered.

## Operation
Register map (word address, access):
- 0 DATA_IN (RO): debounced input state.
- 1 DATA_OUT (RW): output register.
- 2 SET_OUT (WO): DATA_OUT |= wdata.
- 3 CLR_OUT (WO): DATA_OUT &= ~wdata.
- 4 IRQ_MASK (RW): per-channel interrupt enable.
- 5 EDGE_CAP (RW1C): sticky edge flags.
- 6 EDGE_POL (RW): 1 = capture rising edges, 0 = capture falling edges.
- 7: reserved; reads 0, writes ignored.

Rules:
- Bits at or above N_IN / N_OUT read 0 and ignore writes. Reads of write-only registers return 0.
- Input path: a 2-flop synchroniser per bit, then the debouncer (see Configuration).
- Debouncer, per channel: if sync != stable, the counter increments; when the counter is DEB_CYCLES-1 and sync still differs, stable <= sync and the counter clears. If sync == stable, the counter clears. Any glitch shorter than DEB_CYCLES restarts the count.
- Edge detect: stable_d is the previous stable value. A rising edge (stable & ~stable_d) or falling edge (~stable & stable_d) sets EDGE_CAP[i] when it matches EDGE_POL[i].
- EDGE_CAP write-1-to-clear. If a new edge and a clear hit the same bit in the same cycle, the set wins.
- irq <= |(EDGE_CAP & IRQ_MASK), registered.

Reset values:
- stable = stable_d = sync flops = IN_INIT; counters = 0.
- DATA_OUT = OUT_INIT; IRQ_MASK = 0; EDGE_CAP = 0; EDGE_POL = 0.
- avs_readdata = 0; irq = 0.

Reset asserted mid-debounce or mid-transaction discards all progress, and state returns to reset values on the next edge. No edge is captured in the reset-exit cycle.

## Timing
- Read latency is fixed at 1: avs_readdata is valid the cycle after avs_read and holds until the next read. There is no waitrequest.
- A write takes effect at the edge it is sampled. gpio_out changes the same edge DATA_OUT does.
- Pin change to DATA_IN is 2 (sync) + DEB_CYCLES cycles. EDGE_CAP sets 1 cycle after stable changes. irq asserts 1 cycle after EDGE_CAP, and deasserts 1 cycle after the clearing write or mask write.
- A simultaneous read and write to the same address returns the pre-write value.

## Configuration
- GPIO_DEBOUNCE_EN defined: debouncer counters are instantiated as described.
- GPIO_DEBOUNCE_EN undefined: stable <= sync every cycle, and no counters are instantiated. DEB_CYCLES and CNT_W are ignored, and pin-to-DATA_IN latency is 3 cycles.
- Register map, edge logic and irq are identical in both builds.

## Test plan
All scenarios use DEB_CYCLES=4, N_IN=14, N_OUT=10.
- Reset with gpio_in=14'h3FFF, then read addr 0 -> 0x00003FFF; irq=0; gpio_out=0x000.
- Write 0x3FF to addr 1, write 0x00F to addr 3, then read addr 1 -> gpio_out and readdata = 0x3F0. Write 0x001 to addr 2 -> 0x3F1. Write 0xFFFFFFFF to addr 1 -> reads 0x3FF.
- gpio_in[0] falls and holds -> DATA_IN[0]=0 exactly 6 cycles later. A 3-cycle low glitch -> DATA_IN unchanged, no EDGE_CAP.
- EDGE_POL=0, IRQ_MASK=1, press KEY0 -> EDGE_CAP=0x1, then irq=1 one cycle later. Write 0x1 to addr 5 -> EDGE_CAP=0, and irq=0 the following cycle.
- A new edge coincides with a W1C clear of the same bit -> EDGE_CAP bit stays 1. Assert reset mid-debounce (counter=2) -> counter=0, all registers at reset values, no spurious capture.
- Build without GPIO_DEBOUNCE_EN -> a 1-cycle pulse on gpio_in[4] appears in DATA_IN[4] 3 cycles later.
